branch_predict_unit: RTL and testbench
======================================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL provide parameter IDX_BITS, default 10, meaning log2 of pattern-table entries (2-bit counters).
REQ-002 SHALL provide parameter HIST_BITS, default 8, meaning global history width (HIST_BITS <= IDX_BITS).
REQ-003 SHALL provide parameter MODE, default 1, meaning 0 = bimodal index, 1 = gshare index.
REQ-004 SHALL provide parameter BTB_BITS, default 6, meaning log2 of direct-mapped JALR target-buffer entries.
REQ-005 SHALL provide ports: in_clk in 1 clock; in_rst in 1 reset; in_rdy in 1 global enable.
REQ-006 SHALL provide ports: in_query_enable in 1 query valid; in_query_pc in 32 address of instruction; in_query_inst in 32 instruction word.
REQ-007 SHALL provide ports: in_update_enable in 1 commit of a branch/JAL/JALR; in_update_pc in 32; in_update_taken in 1 actual direction; in_update_target in 32 actual target; in_update_hist in HIST_BITS history snapshot; in_update_mispredict in 1 commit mispredicted.
REQ-008 SHALL provide ports: out_predict_enable out 1; out_predict_pc out 32 next fetch address; out_predict_taken out 1; out_predict_hist out HIST_BITS history used for this prediction.
REQ-009 SHALL use one clock in_clk; reset in_rst is synchronous and active-high.

Function
REQ-010 Counter encoding SHALL be 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; predict taken iff bit[1]=1.
REQ-011 Table index SHALL be pc[IDX_BITS+1:2] when MODE=0, and pc[IDX_BITS+1:2] XOR zero-extended history when MODE=1.
REQ-012 Query latency SHALL be exactly one cycle: query accepted at edge N yields out_predict_enable=1 for one cycle after N; low otherwise.
REQ-013 Opcode 1100011 (branch): taken -> pc + sign-extended B-immediate, else pc+4; out_predict_taken = counter bit[1].
REQ-014 Opcode 1101111 (JAL): always pc + sign-extended J-immediate, taken=1; counters untouched.
REQ-015 Opcode 1100111 (JALR): BTB hit (valid and tag pc[31:BTB_BITS+2] match at pc[BTB_BITS+1:2]) -> stored target, taken=1; miss -> pc+4, taken=0.
REQ-016 All other opcodes SHALL yield pc+4, taken=0.
REQ-017 All address arithmetic SHALL be 32-bit modulo 2^32 (wrap-around, no overflow flag).
REQ-018 Speculative history SHALL shift left inserting predicted direction on each branch-opcode query only; out_predict_hist carries pre-shift value.
REQ-019 Update of a branch SHALL saturate its counter (index from in_update_pc and in_update_hist): taken increments, not-taken decrements, holding at 11/00.
REQ-020 Update of a JALR with in_update_taken=1 SHALL write BTB valid, tag and in_update_target.
REQ-021 in_update_mispredict=1 SHALL restore history to {in_update_hist[HIST_BITS-2:0], in_update_taken} for branches, or in_update_hist for others, overriding any same-cycle query shift.
REQ-022 Same-cycle query and update to one entry: query SHALL read pre-update counter/BTB contents; update still written.
REQ-023 in_rdy=0 SHALL freeze tables, history and outputs; inputs that cycle are ignored.
REQ-024 in_rst SHALL take priority over in_rdy and all other inputs.

Reset
REQ-025 On reset all counters SHALL be 01, all BTB valids 0, history 0.
REQ-026 On reset out_predict_enable=0, out_predict_pc=0, out_predict_taken=0, out_predict_hist=0.
REQ-027 Reset asserted mid-operation SHALL discard any pending prediction; first query after deassertion behaves as from power-up.

Verification
REQ-028 Reset, query pc=0x100 BEQ imm=+16 -> next cycle enable=1, pc=0x104, taken=0, hist=0.
REQ-029 Two taken updates for pc=0x100 (hist=0, MODE=0), then query -> pc=0x110, taken=1; two more taken updates keep counter at 11.
REQ-030 Query JAL at 0xFFFFFFF0 imm=+32 -> pc=0x00000010 (wrap), taken=1.
REQ-031 JALR at 0x200: query -> 0x204 taken=0; update taken target 0x4000; re-query -> 0x4000 taken=1; query 0x200+(4<<BTB_BITS) -> miss, pc+4.
REQ-032 MODE=1: three taken-predicted branch queries give hist 000..0111; mispredict update with hist=0, taken=0 -> next query hist=0.
REQ-033 in_rdy=0 with query and update asserted -> no output pulse, counters and history unchanged.

Source files
------------

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: bimodal/gshare direction predictor with JALR target buffer, one-cycle query latency.
// Commits carry no opcode, so every commit trains its counter and every taken commit fills the target buffer.
module branch_predict_unit #(
    parameter int IDX_BITS  = 10,
    parameter int HIST_BITS = 8,
    parameter int MODE      = 1,
    parameter int BTB_BITS  = 6
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_rdy,
    input  logic                 in_query_enable,
    input  logic [31:0]          in_query_pc,
    input  logic [31:0]          in_query_inst,
    input  logic                 in_update_enable,
    input  logic [31:0]          in_update_pc,
    input  logic                 in_update_taken,
    input  logic [31:0]          in_update_target,
    input  logic [HIST_BITS-1:0] in_update_hist,
    input  logic                 in_update_mispredict,
    output logic                 out_predict_enable,
    output logic [31:0]          out_predict_pc,
    output logic                 out_predict_taken,
    output logic [HIST_BITS-1:0] out_predict_hist
);
    localparam int TAG_W = 30 - BTB_BITS;
    localparam int PHT_N = 1 << IDX_BITS;
    localparam int BTB_N = 1 << BTB_BITS;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [1:0]           pht [PHT_N];
    logic [BTB_N-1:0]     btb_valid;
    logic [TAG_W-1:0]     btb_tag [BTB_N];
    logic [31:0]          btb_target [BTB_N];
    logic [HIST_BITS-1:0] hist;

    logic                 is_branch, is_jal, is_jalr, q_hit, q_taken;
    logic [31:0]          imm_b, imm_j, q_target;
    logic [IDX_BITS-1:0]  q_idx, u_idx;
    logic [BTB_BITS-1:0]  q_slot, u_slot;
    logic [1:0]           q_ctr, u_ctr, u_ctr_next;
    logic [HIST_BITS-1:0] hist_next;
    logic                 unused_pc_bits;

    assign unused_pc_bits = ^{in_query_pc[1:0], in_update_pc[1:0]};

    always_comb begin
        is_branch  = in_query_inst[6:0] == OP_BRANCH;
        is_jal     = in_query_inst[6:0] == OP_JAL;
        is_jalr    = in_query_inst[6:0] == OP_JALR;
        imm_b      = {{20{in_query_inst[31]}}, in_query_inst[7], in_query_inst[30:25], in_query_inst[11:8], 1'b0};
        imm_j      = {{12{in_query_inst[31]}}, in_query_inst[19:12], in_query_inst[20], in_query_inst[30:21], 1'b0};
        q_idx      = in_query_pc[IDX_BITS+1:2] ^ (MODE == 1 ? IDX_BITS'(hist) : '0);
        q_slot     = in_query_pc[BTB_BITS+1:2];
        q_hit      = btb_valid[q_slot] && btb_tag[q_slot] == in_query_pc[31:BTB_BITS+2];
        q_ctr      = pht[q_idx];
        q_taken    = is_branch ? q_ctr[1] : (is_jal | (is_jalr & q_hit));
        q_target   = (is_branch & q_ctr[1]) ? in_query_pc + imm_b :
                     is_jal                 ? in_query_pc + imm_j :
                     (is_jalr & q_hit)      ? btb_target[q_slot]  : in_query_pc + 32'd4;
        u_idx      = in_update_pc[IDX_BITS+1:2] ^ (MODE == 1 ? IDX_BITS'(in_update_hist) : '0);
        u_slot     = in_update_pc[BTB_BITS+1:2];
        u_ctr      = pht[u_idx];
        u_ctr_next = in_update_taken ? (u_ctr == 2'b11 ? u_ctr : u_ctr + 2'b01)
                                     : (u_ctr == 2'b00 ? u_ctr : u_ctr - 2'b01);
        // a committed mispredict wins over any speculative shift in the same cycle
        hist_next  = (in_update_enable & in_update_mispredict) ? ((in_update_hist << 1) | HIST_BITS'(in_update_taken)) :
                     (in_query_enable & is_branch)             ? ((hist << 1) | HIST_BITS'(q_ctr[1]))             : hist;
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
            btb_valid          <= '0;
            hist               <= '0;
            out_predict_enable <= 1'b0;
            out_predict_pc     <= '0;
            out_predict_taken  <= 1'b0;
            out_predict_hist   <= '0;
        end else if (in_rdy) begin
            out_predict_enable <= in_query_enable;
            if (in_query_enable) begin
                out_predict_pc    <= q_target;
                out_predict_taken <= q_taken;
                out_predict_hist  <= hist;
            end
            hist <= hist_next;
            if (in_update_enable) begin
                pht[u_idx] <= u_ctr_next;
                if (in_update_taken) btb_valid[u_slot] <= 1'b1;
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst && in_rdy && in_update_enable && in_update_taken) begin
            btb_tag[u_slot]    <= in_update_pc[31:BTB_BITS+2];
            btb_target[u_slot] <= in_update_target;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed scenarios plus randomized traffic checked against a behavioural predictor model.
module tb_branch_predict_unit;
    logic        in_clk = 1'b0;
    logic        in_rst = 1'b1, in_rdy = 1'b1;
    logic        in_query_enable = 1'b0, in_update_enable = 1'b0;
    logic [31:0] in_query_pc = '0, in_query_inst = '0, in_update_pc = '0, in_update_target = '0;
    logic        in_update_taken = 1'b0, in_update_mispredict = 1'b0;
    logic [7:0]  in_update_hist = '0;
    logic        out_predict_enable, out_predict_taken;
    logic [31:0] out_predict_pc;
    logic [7:0]  out_predict_hist;

    branch_predict_unit dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_rdy(in_rdy),
        .in_query_enable(in_query_enable), .in_query_pc(in_query_pc), .in_query_inst(in_query_inst),
        .in_update_enable(in_update_enable), .in_update_pc(in_update_pc), .in_update_taken(in_update_taken),
        .in_update_target(in_update_target), .in_update_hist(in_update_hist),
        .in_update_mispredict(in_update_mispredict),
        .out_predict_enable(out_predict_enable), .out_predict_pc(out_predict_pc),
        .out_predict_taken(out_predict_taken), .out_predict_hist(out_predict_hist)
    );

    always #5 in_clk = ~in_clk;

    localparam logic [31:0] JALR_INST = 32'h0000_8067;

    int          n_vec = 0, n_err = 0;
    int          m_ctr [1024];
    bit          m_bv [64];
    int unsigned m_bpc [64];
    logic [31:0] m_btgt [64];
    int unsigned m_hist;
    logic        exp_en, exp_taken;
    logic [31:0] exp_pc;
    logic [7:0]  exp_hist;

    function automatic logic [31:0] sext(logic [31:0] v, int bits);
        return v[bits-1] ? v - (32'd1 << bits) : v;
    endfunction

    function automatic logic [31:0] enc_b(logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'h6f};
    endfunction

    function automatic logic [41:0] got();
        return {out_predict_enable, out_predict_taken, out_predict_pc, out_predict_hist};
    endfunction

    task automatic drive(input logic qe, input logic [31:0] qpc, input logic [31:0] qi,
                         input logic ue, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt, input logic [7:0] uh, input logic um);
        in_query_enable = qe; in_query_pc = qpc; in_query_inst = qi;
        in_update_enable = ue; in_update_pc = upc; in_update_taken = ut;
        in_update_target = utgt; in_update_hist = uh; in_update_mispredict = um;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // advance the reference model by one accepted cycle, then clock the DUT
    task automatic tick();
        int unsigned p, i, op, idx, slot, nh;
        bit tk;
        logic [31:0] tgt, imm;
        if (in_rst) begin
            for (int k = 0; k < 1024; k++) m_ctr[k] = 1;
            for (int k = 0; k < 64; k++) m_bv[k] = 0;
            m_hist = 0;
            exp_en = 0; exp_taken = 0; exp_pc = 0; exp_hist = 0;
        end else if (in_rdy) begin
            p = in_query_pc; i = in_query_inst; op = i & 127;
            tk = 0; nh = m_hist;
            exp_en = in_query_enable;
            if (in_query_enable) begin
                idx = ((p >> 2) ^ m_hist) % 1024;
                slot = (p >> 2) % 64;
                if (op == 'h63) begin
                    imm = (((i >> 31) & 1) << 12) | (((i >> 7) & 1) << 11) | (((i >> 25) & 63) << 5) | (((i >> 8) & 15) << 1);
                    tk = m_ctr[idx] >= 2;
                    tgt = tk ? p + sext(imm, 13) : p + 4;
                    nh = (m_hist * 2 + tk) % 256;
                end else if (op == 'h6f) begin
                    imm = (((i >> 31) & 1) << 20) | (((i >> 12) & 255) << 12) | (((i >> 20) & 1) << 11) | (((i >> 21) & 1023) << 1);
                    tk = 1;
                    tgt = p + sext(imm, 21);
                end else if (op == 'h67) begin
                    tk = m_bv[slot] && m_bpc[slot] == (p >> 2);
                    tgt = tk ? m_btgt[slot] : p + 4;
                end else begin
                    tgt = p + 4;
                end
                exp_taken = tk; exp_pc = tgt; exp_hist = 8'(m_hist);
            end
            if (in_update_enable) begin
                idx = ((in_update_pc >> 2) ^ in_update_hist) % 1024;
                if (in_update_taken) begin
                    if (m_ctr[idx] < 3) m_ctr[idx]++;
                    slot = (in_update_pc >> 2) % 64;
                    m_bv[slot] = 1; m_bpc[slot] = in_update_pc >> 2; m_btgt[slot] = in_update_target;
                end else if (m_ctr[idx] > 0) m_ctr[idx]--;
                if (in_update_mispredict) nh = (in_update_hist * 2 + in_update_taken) % 256;
            end
            m_hist = nh;
        end
        @(posedge in_clk);
        #1;
    endtask

    task automatic test_reset();
        in_rst = 1; drive(1, 32'h100, enc_b(13'd16), 1, 32'h100, 1, 32'h40, 0, 1); tick();
        n_vec++;
        if (got() !== 42'h0) begin n_err++; $display("FAIL reset_state got %h want %h", got(), 42'h0); end
        in_rst = 0; drive(1, 32'h100, enc_b(13'd16), 0, 0, 0, 0, 0, 0); tick();
        in_rst = 1; tick();
        n_vec++;
        if (got() !== 42'h0) begin n_err++; $display("FAIL reset_discard got %h want %h", got(), 42'h0); end
        in_rst = 0; idle(); tick();
    endtask

    task automatic test_branch_basic();
        drive(1, 32'h100, enc_b(13'd16), 0, 0, 0, 0, 0, 0); tick();
        n_vec++;
        if (got() !== {1'b1, 1'b0, 32'h104, 8'h00}) begin n_err++; $display("FAIL beq_nt got %h want %h", got(), {1'b1, 1'b0, 32'h104, 8'h00}); end
        idle(); tick();
        n_vec++;
        if (out_predict_enable !== 1'b0) begin n_err++; $display("FAIL pulse_width got %b want 0", out_predict_enable); end
    endtask

    task automatic test_counter_train();
        repeat (2) begin drive(0, 0, 0, 1, 32'h100, 1, 32'h110, 0, 0); tick(); end
        drive(1, 32'h100, enc_b(13'd16), 0, 0, 0, 0, 0, 0); tick();
        n_vec++;
        if (got() !== {1'b1, 1'b1, 32'h110, 8'h00}) begin n_err++; $display("FAIL trained_taken got %h want %h", got(), {1'b1, 1'b1, 32'h110, 8'h00}); end
        repeat (2) begin drive(0, 0, 0, 1, 32'h100, 1, 32'h110, 0, 0); tick(); end
        drive(0, 0, 0, 1, 32'h100, 0, 0, 0, 1); tick();
        drive(1, 32'h100, enc_b(13'd16), 0, 0, 0, 0, 0, 0); tick();
        n_vec++;
        if (got() !== {1'b1, 1'b1, 32'h110, 8'h00}) begin n_err++; $display("FAIL saturate got %h want %h", got(), {1'b1, 1'b1, 32'h110, 8'h00}); end
    endtask

    task automatic test_jal_wrap();
        drive(1, 32'hFFFF_FFF0, enc_j(21'd32), 0, 0, 0, 0, 0, 0); tick();
        n_vec++;
        if (got() !== {1'b1, 1'b1, 32'h10, 8'h01}) begin n_err++; $display("FAIL jal_wrap got %h want %h", got(), {1'b1, 1'b1, 32'h10, 8'h01}); end
    endtask

    task automatic test_jalr_btb();
        drive(1, 32'h200, JALR_INST, 0, 0, 0, 0, 0, 0); tick();
        n_vec++;
        if (got() !== {1'b1, 1'b0, 32'h204, 8'h01}) begin n_err++; $display("FAIL jalr_miss got %h want %h", got(), {1'b1, 1'b0, 32'h204, 8'h01}); end
        drive(0, 0, 0, 1, 32'h200, 1, 32'h4000, 0, 0); tick();
        drive(1, 32'h200, JALR_INST, 0, 0, 0, 0, 0, 0); tick();
        n_vec++;
        if (got() !== {1'b1, 1'b1, 32'h4000, 8'h01}) begin n_err++; $display("FAIL jalr_hit got %h want %h", got(), {1'b1, 1'b1, 32'h4000, 8'h01}); end
        drive(1, 32'h300, JALR_INST, 0, 0, 0, 0, 0, 0); tick();
        n_vec++;
        if (got() !== {1'b1, 1'b0, 32'h304, 8'h01}) begin n_err++; $display("FAIL jalr_alias got %h want %h", got(), {1'b1, 1'b0, 32'h304, 8'h01}); end
        drive(1, 32'h400, JALR_INST, 1, 32'h400, 1, 32'h8000, 0, 0); tick();
        n_vec++;
        if (got() !== {1'b1, 1'b0, 32'h404, 8'h01}) begin n_err++; $display("FAIL same_cycle_old got %h want %h", got(), {1'b1, 1'b0, 32'h404, 8'h01}); end
        drive(1, 32'h400, JALR_INST, 0, 0, 0, 0, 0, 0); tick();
        n_vec++;
        if (got() !== {1'b1, 1'b1, 32'h8000, 8'h01}) begin n_err++; $display("FAIL same_cycle_new got %h want %h", got(), {1'b1, 1'b1, 32'h8000, 8'h01}); end
    endtask

    task automatic test_rdy_freeze();
        idle(); tick();
        in_rdy = 0; drive(1, 32'h100, enc_b(13'd16), 1, 32'h104, 1, 32'h900, 0, 0); tick();
        n_vec++;
        if (out_predict_enable !== 1'b0) begin n_err++; $display("FAIL freeze_pulse got %b want 0", out_predict_enable); end
        in_rdy = 1; idle(); tick();
        drive(1, 32'h100, enc_b(13'd16), 0, 0, 0, 0, 0, 0); tick();
        n_vec++;
        if (got() !== {1'b1, 1'b0, 32'h104, 8'h01}) begin n_err++; $display("FAIL freeze_state got %h want %h", got(), {1'b1, 1'b0, 32'h104, 8'h01}); end
    endtask

    task automatic test_hist_mispredict();
        logic [7:0] hs [3] = '{8'd0, 8'd1, 8'd3};
        in_rst = 1; idle(); tick(); in_rst = 0;
        foreach (hs[k]) repeat (2) begin drive(0, 0, 0, 1, 32'h800, 1, 32'h810, hs[k], 0); tick(); end
        foreach (hs[k]) begin
            drive(1, 32'h800, enc_b(13'd16), 0, 0, 0, 0, 0, 0); tick();
            n_vec++;
            if (got() !== {1'b1, 1'b1, 32'h810, hs[k]}) begin n_err++; $display("FAIL hist_shift%0d got %h want %h", k, got(), {1'b1, 1'b1, 32'h810, hs[k]}); end
        end
        drive(1, 32'h800, enc_j(21'd8), 0, 0, 0, 0, 0, 0); tick();
        n_vec++;
        if (got() !== {1'b1, 1'b1, 32'h808, 8'h07}) begin n_err++; $display("FAIL hist_seven got %h want %h", got(), {1'b1, 1'b1, 32'h808, 8'h07}); end
        drive(0, 0, 0, 1, 32'h800, 0, 0, 0, 1); tick();
        drive(1, 32'h800, enc_b(13'd16), 0, 0, 0, 0, 0, 0); tick();
        n_vec++;
        if (got() !== {1'b1, 1'b1, 32'h810, 8'h00}) begin n_err++; $display("FAIL hist_restore got %h want %h", got(), {1'b1, 1'b1, 32'h810, 8'h00}); end
    endtask

    task automatic test_random();
        logic [31:0] qpc, qi, upc;
        logic [41:0] want;
        in_rst = 1; idle(); tick(); in_rst = 0;
        for (int n = 0; n < 600; n++) begin
            in_rst = $urandom_range(0, 199) == 0;
            in_rdy = $urandom_range(0, 9) != 0;
            qpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FF00 + ($urandom_range(0, 63) << 2)
                                              : 32'h1000 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 15) << 2);
            upc = 32'h1000 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 15) << 2);
            case ($urandom_range(0, 3))
                0: qi = enc_b(13'($urandom) & 13'h1FFE);
                1: qi = enc_j(21'($urandom) & 21'h1FFFFE);
                2: qi = JALR_INST;
                default: qi = ($urandom & 32'hFFFF_FF80) | 32'h13;
            endcase
            drive($urandom_range(0, 9) < 7, qpc, qi, $urandom_range(0, 1), upc, $urandom_range(0, 1),
                  $urandom & 32'hFFFF_FFFC, 8'($urandom), $urandom_range(0, 4) == 0);
            tick();
            want = {exp_en, exp_taken, exp_pc, exp_hist};
            n_vec++;
            if (got() !== want) begin n_err++; $display("FAIL random%0d got %h want %h", n, got(), want); end
        end
        in_rst = 0; in_rdy = 1; idle(); tick();
    endtask

    initial begin
        test_reset();
        test_branch_basic();
        test_counter_train();
        test_jal_wrap();
        test_jalr_btb();
        test_rdy_freeze();
        test_hist_mispredict();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
